// File: rtl/stopwatch_timer.sv
// stopwatch_timer: BCD mm:ss elapsed-time datapath for the stopwatch.
// A prescaler divides clk down to a 1 s tick. Time freezes on pause and clears on idle.
// Optional lap/freeze display feature: define STOPWATCH_LAP_EN.
module stopwatch_timer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int PRE_W    = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic       enable,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
    output logic       lap_hold,
`endif
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       sec_tick,
    output logic       rollover
);

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    bcd_time_t        live, live_inc, live_d;
    logic [PRE_W-1:0] pre, pre_d;
    logic             clear, last_cnt, wrap, tick_d, roll_d;

    // idle (00) and illegal (11) both clear the stopwatch
    assign clear    = (state[1] == state[0]);
    assign last_cnt = (pre == PRE_W'(TICK_DIV - 1));

    // BCD ripple increment, each digit carries only when the lower one wraps
    always_comb begin
        live_inc = live;
        wrap     = 1'b0;
        live_inc.so = live.so + 4'd1;
        if (live.so == 4'd9) begin
            live_inc.so = 4'd0;
            live_inc.st = live.st + 4'd1;
            if (live.st == 4'd5) begin
                live_inc.st = 4'd0;
                live_inc.mo = live.mo + 4'd1;
                if (live.mo == 4'd9) begin
                    live_inc.mo = 4'd0;
                    live_inc.mt = live.mt + 4'd1;
                    if (live.mt == 4'd5) begin
                        live_inc.mt = 4'd0;
                        wrap        = 1'b1;
                    end
                end
            end
        end
    end

    // next live time / prescaler: clear beats count, otherwise hold
    always_comb begin
        live_d = live;
        pre_d  = pre;
        tick_d = 1'b0;
        roll_d = 1'b0;
        if (clear) begin
            live_d = '0;
            pre_d  = '0;
        end else if (enable) begin
            if (last_cnt) begin
                pre_d  = '0;
                live_d = live_inc;
                tick_d = 1'b1;
                roll_d = wrap;
            end else begin
                pre_d = pre + PRE_W'(1);
            end
        end
    end

    // live time, prescaler and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            live     <= '0;
            pre      <= '0;
            sec_tick <= 1'b0;
            rollover <= 1'b0;
        end else begin
            live     <= live_d;
            pre      <= pre_d;
            sec_tick <= tick_d;
            rollover <= roll_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    bcd_time_t lap_time, lap_time_d, disp;
    logic      lap_hold_d;

    // lap toggles the frozen display; capture uses the pre-increment live value
    always_comb begin
        lap_time_d = lap_time;
        lap_hold_d = lap_hold;
        if (clear) begin
            lap_hold_d = 1'b0;
        end else if (lap) begin
            if (!lap_hold) lap_time_d = live;
            lap_hold_d = !lap_hold;
        end
    end

    // lap registers and a registered display mux so digit outputs stay glitch-free
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_time <= '0;
            lap_hold <= 1'b0;
            disp     <= '0;
        end else begin
            lap_time <= lap_time_d;
            lap_hold <= lap_hold_d;
            disp     <= lap_hold_d ? lap_time_d : live_d;
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = disp;
`else
    assign {min_tens, min_ones, sec_tens, sec_ones} = live;
`endif

endmodule
